// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC bus arbiter slice.
package rtc_bus_pkg;

  localparam int N_REQ       = 3;
  localparam int T_PHASE_DEF = 10;

  localparam int REQ_INIT = 0;
  localparam int REQ_CFG  = 1;
  localparam int REQ_RD   = 2;

  typedef enum logic [2:0] {
    IDLE,
    A_SETUP,
    A_STROBE,
    A_HOLD,
    D_SETUP,
    D_STROBE,
    D_HOLD,
    DONE
  } bus_state_e;

  function automatic logic is_addr_phase(
    input bus_state_e s
  );
    return (s == A_SETUP) ||
           (s == A_STROBE) ||
           (s == A_HOLD);
  endfunction

  function automatic logic is_data_phase(
    input bus_state_e s
  );
    return (s == D_SETUP) ||
           (s == D_STROBE) ||
           (s == D_HOLD);
  endfunction

  function automatic logic is_timed(
    input bus_state_e s
  );
    return is_addr_phase(s) ||
           is_data_phase(s);
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter_if.sv
// Requester-side handshake bundle of the RTC bus arbiter.
interface rtc_bus_arbiter_if;
  import rtc_bus_pkg::*;

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   we;
  logic [8*N_REQ-1:0] addr_in;
  logic [8*N_REQ-1:0] wdata_in;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         rdata;
  logic               busy;

  modport master (
    output req,
    output we,
    output addr_in,
    output wdata_in,
    input  ack,
    input  rdata,
    input  busy
  );

  modport slave (
    input  req,
    input  we,
    input  addr_in,
    input  wdata_in,
    output ack,
    output rdata,
    output busy
  );

endinterface

// File: rtl/rtc_bus_grant.sv
// One-hot requester selection; RTC_BUS_RR_EN rotates 1/2 behind 0.
module rtc_bus_grant
  import rtc_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
`ifdef RTC_BUS_RR_EN
  input  logic             prefer_cfg,
`endif
  output logic [N_REQ-1:0] gnt
);

  logic r0;
  logic r1;
  logic r2;

  assign r0 = req[REQ_INIT];
  assign r1 = req[REQ_CFG];
  assign r2 = req[REQ_RD];

  always_comb begin
    gnt = '0;
    unique case (1'b1)
      r0: gnt[REQ_INIT] = 1'b1;
`ifdef RTC_BUS_RR_EN
      // 1 and 2 only contend when both ask.
      !r0 && r1 && (prefer_cfg || !r2):
        gnt[REQ_CFG] = 1'b1;
      !r0 && r2 && (!prefer_cfg || !r1):
        gnt[REQ_RD] = 1'b1;
`else
      !r0 && r1:
        gnt[REQ_CFG] = 1'b1;
      !r0 && !r1 && r2:
        gnt[REQ_RD] = 1'b1;
`endif
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// RTC bus sequencer/arbiter top; RTC_BUS_RR_EN enables 1/2 round-robin.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEF
) (
  input  logic             CLK,
  input  logic             Reset,
  rtc_bus_arbiter_if.slave bus_if,
  output logic             CSO,
  output logic             ADO,
  output logic             WRO,
  output logic             RDO,
  inout  wire  [7:0]       Bus_Dato_Dir
);

  localparam int CW = $clog2(T_PHASE + 1);
  localparam logic [CW-1:0] LAST =
    CW'(T_PHASE - 1);

  bus_state_e state;
  bus_state_e state_d;

  logic [CW-1:0] cnt;
  logic          phase_end;
  logic          capture;

  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] gnt_q;
  logic             we_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;

  logic       sel_we;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;
  logic       cur_we;
  logic [7:0] cur_addr;
  logic [7:0] cur_wdata;

  logic             cs_d;
  logic             ad_d;
  logic             wr_d;
  logic             rd_d;
  logic             oe_d;
  logic             oe_q;
  logic [7:0]       bus_d;
  logic [7:0]       bus_q;
  logic [N_REQ-1:0] ack_d;
  logic             busy_d;

  assign capture =
    (state == IDLE) && (|bus_if.req);
  assign phase_end = (cnt == LAST);

`ifdef RTC_BUS_RR_EN
  logic prefer_cfg;

  rtc_bus_grant u_grant (
    .req        (bus_if.req),
    .prefer_cfg (prefer_cfg),
    .gnt        (gnt)
  );

  // Last served of 1/2 drops to lowest.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      prefer_cfg <= 1'b1;
    end else if (capture) begin
      if (gnt[REQ_CFG])
        prefer_cfg <= 1'b0;
      else if (gnt[REQ_RD])
        prefer_cfg <= 1'b1;
    end
  end
`else
  rtc_bus_grant u_grant (
    .req (bus_if.req),
    .gnt (gnt)
  );
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_we    |= bus_if.we[i] & gnt[i];
      sel_addr  |= bus_if.addr_in[8*i +: 8]
                 & {8{gnt[i]}};
      sel_wdata |= bus_if.wdata_in[8*i +: 8]
                 & {8{gnt[i]}};
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      gnt_q   <= gnt;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
  end

  // Outputs are registered from state_d, so the
  // capture cycle must see the live selection.
  assign cur_we =
    (state == IDLE) ? sel_we : we_q;
  assign cur_addr =
    (state == IDLE) ? sel_addr : addr_q;
  assign cur_wdata =
    (state == IDLE) ? sel_wdata : wdata_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (|bus_if.req) state_d = A_SETUP;
      A_SETUP:
        if (phase_end) state_d = A_STROBE;
      A_STROBE:
        if (phase_end) state_d = A_HOLD;
      A_HOLD:
        if (phase_end) state_d = D_SETUP;
      D_SETUP:
        if (phase_end) state_d = D_STROBE;
      D_STROBE:
        if (phase_end) state_d = D_HOLD;
      D_HOLD:
        if (phase_end) state_d = DONE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      cnt <= '0;
    else if (state_d != state)
      cnt <= '0;
    else if (is_timed(state))
      cnt <= cnt + CW'(1);
  end

  always_comb begin
    cs_d   = 1'b1;
    ad_d   = 1'b1;
    wr_d   = 1'b1;
    rd_d   = 1'b1;
    oe_d   = 1'b0;
    bus_d  = cur_addr;
    ack_d  = '0;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      A_SETUP, A_HOLD: begin
        cs_d = 1'b0;
        ad_d = 1'b0;
        oe_d = 1'b1;
      end
      A_STROBE: begin
        cs_d = 1'b0;
        ad_d = 1'b0;
        wr_d = 1'b0;
        oe_d = 1'b1;
      end
      D_SETUP, D_HOLD: begin
        cs_d  = 1'b0;
        oe_d  = cur_we;
        bus_d = cur_wdata;
      end
      // Drive and RDO are mutually exclusive on we.
      D_STROBE: begin
        cs_d  = 1'b0;
        wr_d  = !cur_we;
        rd_d  = cur_we;
        oe_d  = cur_we;
        bus_d = cur_wdata;
      end
      DONE:
        ack_d = gnt_q;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      CSO         <= 1'b1;
      ADO         <= 1'b1;
      WRO         <= 1'b1;
      RDO         <= 1'b1;
      oe_q        <= 1'b0;
      bus_q       <= '0;
      bus_if.ack  <= '0;
      bus_if.busy <= 1'b0;
    end else begin
      CSO         <= cs_d;
      ADO         <= ad_d;
      WRO         <= wr_d;
      RDO         <= rd_d;
      oe_q        <= oe_d;
      bus_q       <= bus_d;
      bus_if.ack  <= ack_d;
      bus_if.busy <= busy_d;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)
      bus_if.rdata <= '0;
    else if (state == D_STROBE &&
             phase_end && !we_q)
      bus_if.rdata <= Bus_Dato_Dir;
  end

  assign Bus_Dato_Dir = oe_q ? bus_q : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomised bench for rtc_bus_arbiter against a timeline model.
module tb_rtc_bus_arbiter;
  import rtc_bus_pkg::*;

  localparam int TP = 2;
  localparam int TL = 6*TP + 1;
`ifdef RTC_BUS_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [23:0] RST_PINS =
    {4'hF, 8'hFF, 3'b000, 8'h00, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  logic cso_w, ado_w, wro_w, rdo_w;
  wire [7:0] bus;
  logic [7:0] rd_val = 8'h00;
  int n_cmp = 0;
  int n_bad = 0;

  rtc_bus_arbiter_if rq();

  rtc_bus_arbiter #(.T_PHASE(TP)) dut (
    .CLK          (clk),
    .Reset        (rst_n),
    .bus_if       (rq),
    .CSO          (cso_w),
    .ADO          (ado_w),
    .WRO          (wro_w),
    .RDO          (rdo_w),
    .Bus_Dato_Dir (bus)
  );

  pullup pu (bus);
  assign bus = (rdo_w == 1'b0) ? rd_val : 8'hzz;

  always #5 clk = ~clk;

  wire [23:0] pins = {cso_w, ado_w, wro_w, rdo_w,
                      bus, rq.ack, rq.rdata, rq.busy};

  a_no_contention: assert property (
    @(negedge clk) disable iff (!chk_en)
    !(dut.oe_q && !rdo_w))
  else $error("FAIL bus_contention oe=%b rdo=%b",
              dut.oe_q, rdo_w);

  // Model: one transaction = offsets 1..TL after capture.
  logic       m_busy;
  int         m_t;
  int         m_g;
  logic       m_we;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic       m_pref1;
  int         m_pick;

  function automatic int pick(logic [2:0] r, logic p);
    if (r[0]) return 0;
    if (r[1] && (!r[2] || !RR || p)) return 1;
    return 2;
  endfunction

  assign m_pick = pick(rq.req, m_pref1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_t <= 0; m_g <= 0;
      m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      m_rdata <= '0; m_pref1 <= 1'b1;
    end else if (m_busy) begin
      if (m_t == TL) begin
        m_busy <= 1'b0; m_t <= 0;
      end else m_t <= m_t + 1;
      if (m_t == 5*TP && !m_we) m_rdata <= rd_val;
    end else if (rq.req != 0) begin
      m_busy  <= 1'b1;
      m_t     <= 1;
      m_g     <= m_pick;
      m_we    <= rq.we[m_pick];
      m_addr  <= rq.addr_in[8*m_pick +: 8];
      m_wdata <= rq.wdata_in[8*m_pick +: 8];
      if (m_pick == 1) m_pref1 <= 1'b0;
      else if (m_pick == 2) m_pref1 <= 1'b1;
    end
  end

  function automatic logic [23:0] model_pins();
    int k;
    logic cs, ad, wr, rd;
    logic [7:0] b;
    logic [2:0] a;
    k  = m_busy ? m_t : 0;
    cs = !(k >= 1 && k <= 6*TP);
    ad = !(k >= 1 && k <= 3*TP);
    wr = !((k >= TP+1 && k <= 2*TP) ||
           (m_we && k >= 4*TP+1 && k <= 5*TP));
    rd = !(!m_we && k >= 4*TP+1 && k <= 5*TP);
    b  = 8'hFF;
    if (k >= 1 && k <= 3*TP) b = m_addr;
    else if (m_we && k > 3*TP && k <= 6*TP) b = m_wdata;
    else if (!rd) b = rd_val;
    a = (k == TL) ? 3'(1 << m_g) : 3'b000;
    return {cs, ad, wr, rd, b, a, m_rdata, m_busy};
  endfunction

  function automatic int idx_of(logic [2:0] a);
    return a[0] ? 0 : (a[1] ? 1 : 2);
  endfunction

  task automatic do_reset();
    rq.req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rq.req = 3'b111; rq.we = 3'b111;
    rq.addr_in = '0; rq.wdata_in = '0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (pins !== RST_PINS) begin
        n_bad++;
        $display("FAIL reset c%0d: got %h want %h",
                 c, pins, RST_PINS);
      end
      @(negedge clk);
    end
    rq.req = '0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    int c = 0;
    int ack_c = -1;
    rq.we       = 3'b010;
    rq.addr_in  = {8'h00, 8'h21, 8'h00};
    rq.wdata_in = {8'h00, 8'h45, 8'h00};
    rq.req      = 3'b010;
    while ((rq.req != 0 || m_busy) && c < 40) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL write c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      if (rq.ack != 0) begin
        n_cmp++;
        if (rq.ack !== 3'b010 || c + 1 != TL) begin
          n_bad++;
          $display("FAIL write_ack: got %b at %0d want 010 at %0d",
                   rq.ack, c + 1, TL);
        end
        ack_c = c;
        rq.req = rq.req & ~rq.ack;
      end
      c++;
    end
    n_cmp++;
    if (ack_c < 0) begin
      n_bad++;
      $display("FAIL write_timeout: got no ack want ack[1]");
    end
  endtask

  task automatic test_read();
    int c = 0;
    rq.we      = 3'b000;
    rq.addr_in = {8'h22, 8'h00, 8'h00};
    rd_val     = 8'h37;
    rq.req     = 3'b100;
    while ((rq.req != 0 || m_busy) && c < 40) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL read c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      if (rq.ack != 0) begin
        n_cmp++;
        if (rq.ack !== 3'b100 || rq.rdata !== 8'h37) begin
          n_bad++;
          $display("FAIL read_ack: got %b/%h want 100/37",
                   rq.ack, rq.rdata);
        end
        rq.req = rq.req & ~rq.ack;
      end
      c++;
    end
    rd_val = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (rq.rdata !== 8'h37 || pins !== model_pins()) begin
        n_bad++;
        $display("FAIL read_hold: got %h want 37", rq.rdata);
      end
    end
  endtask

  task automatic test_simultaneous();
    int c = 0;
    int order[$];
    int ack_at[$];
    do_reset();
    rq.we = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      rq.addr_in[8*i +: 8]  = 8'($urandom_range(0, 254));
      rq.wdata_in[8*i +: 8] = 8'($urandom_range(0, 254));
    end
    rd_val = 8'($urandom_range(0, 254));
    rq.req = 3'b111;
    while ((rq.req != 0 || m_busy) && c < 3*TL + 10) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL simul c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      if (rq.ack != 0) begin
        order.push_back(idx_of(rq.ack));
        ack_at.push_back(c);
        rq.req = rq.req & ~rq.ack;
      end
      c++;
    end
    n_cmp++;
    if (order.size() != 3) begin
      n_bad++;
      $display("FAIL simul_count: got %0d acks want 3",
               order.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (order[i] != i) begin
          n_bad++;
          $display("FAIL simul_order[%0d]: got %0d want %0d",
                   i, order[i], i);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (ack_at[i] - ack_at[i-1] != TL + 1) begin
          n_bad++;
          $display("FAIL simul_gap[%0d]: got %0d want %0d",
                   i, ack_at[i] - ack_at[i-1], TL + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int c = 0;
    int order[$];
`ifdef RTC_BUS_RR_EN
    int exp_o[4] = '{1, 2, 0, 1};
`else
    int exp_o[4] = '{1, 1, 0, 1};
`endif
    do_reset();
    rq.we = 3'b011;
    for (int i = 0; i < 3; i++) begin
      rq.addr_in[8*i +: 8]  = 8'($urandom_range(0, 254));
      rq.wdata_in[8*i +: 8] = 8'($urandom_range(0, 254));
    end
    rd_val = 8'($urandom_range(0, 254));
    rq.req = 3'b110;
    while (order.size() < 4 && c < 5*TL + 10) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL b2b c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      if (rq.ack != 0) begin
        order.push_back(idx_of(rq.ack));
        rq.req = rq.req | (rq.ack & 3'b110);
        rq.req = rq.req & ~(rq.ack & 3'b001);
        if (order.size() == 2) rq.req[0] = 1'b1;
      end
      c++;
    end
    rq.req = '0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL b2b_drain: got %h want %h",
                 pins, model_pins());
      end
    end
    n_cmp++;
    if (order.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (order[i] != exp_o[i]) begin
          n_bad++;
          $display("FAIL b2b_order[%0d]: got %0d want %0d",
                   i, order[i], exp_o[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    int acks = 0;
    do_reset();
    rq.we = 3'b010;
    rq.addr_in[15:8]  = 8'($urandom_range(0, 254));
    rq.wdata_in[15:8] = 8'($urandom_range(0, 254));
    rq.req = 3'b010;
    while (!(m_busy && m_t == 4*TP + 1) && c < 40) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL rmid_pre c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      c++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pins !== RST_PINS) begin
      n_bad++;
      $display("FAIL rmid_abort: got %h want %h",
               pins, RST_PINS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
    while ((rq.req != 0 || m_busy) && c < 40) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL rmid_post c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      if (rq.ack != 0) begin
        acks++;
        rq.req = rq.req & ~rq.ack;
      end
      c++;
    end
    n_cmp++;
    if (acks != 1) begin
      n_bad++;
      $display("FAIL rmid_acks: got %0d want 1", acks);
    end
  endtask

  task automatic test_drop();
    int c = 0;
    int acks = 0;
    rq.we = 3'b010;
    rq.addr_in[15:8]  = 8'($urandom_range(0, 254));
    rq.wdata_in[15:8] = 8'($urandom_range(0, 254));
    rq.req = 3'b010;
    while ((rq.req != 0 || m_busy) && c < 40) begin
      @(negedge clk);
      n_cmp++;
      if (pins !== model_pins()) begin
        n_bad++;
        $display("FAIL drop c%0d: got %h want %h",
                 c, pins, model_pins());
      end
      if (m_busy && m_t == 2*TP + 1) rq.req[1] = 1'b0;
      if (rq.ack == 3'b010) acks++;
      c++;
    end
    n_cmp++;
    if (acks != 1) begin
      n_bad++;
      $display("FAIL drop_ack: got %0d want 1", acks);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int c = 0;
      rq.we = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        rq.addr_in[8*i +: 8]  = 8'($urandom_range(0, 254));
        rq.wdata_in[8*i +: 8] = 8'($urandom_range(0, 254));
      end
      rd_val = 8'($urandom_range(0, 254));
      rq.req = 3'($urandom_range(1, 7));
      while ((rq.req != 0 || m_busy) && c < 3*TL + 10) begin
        @(negedge clk);
        n_cmp++;
        if (pins !== model_pins()) begin
          n_bad++;
          $display("FAIL random it%0d c%0d: got %h want %h",
                   it, c, pins, model_pins());
        end
        rq.req = rq.req & ~rq.ack;
        c++;
      end
      n_cmp++;
      if (rq.req != 0 || m_busy) begin
        n_bad++;
        $display("FAIL random_timeout it%0d: req %b want 000",
                 it, rq.req);
      end
    end
  endtask

  initial begin
    rq.req = '0; rq.we = '0;
    rq.addr_in = '0; rq.wdata_in = '0;
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
